// File: rtl/program_loader_if.sv
// Write-side bundle of the serial program loader: memory write strobe and bus plus CPU hold and status flags.
// The loader drives the master modport; memory and CPU-reset logic use the slave modport.
interface program_loader_if #(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned PC_WIDTH          = 8
);
    logic                         writeEnable;
    logic [PC_WIDTH-1:0]          writeAddress;
    logic [INSTRUCTION_WIDTH-1:0] writeData;
    logic                         cpuHold;
    logic                         loadDone;
    logic                         frameError;
    logic                         checksumError;

    modport master (
        output writeEnable,
        output writeAddress,
        output writeData,
        output cpuHold,
        output loadDone,
        output frameError,
        output checksumError
    );

    modport slave (
        input writeEnable,
        input writeAddress,
        input writeData,
        input cpuHold,
        input loadDone,
        input frameError,
        input checksumError
    );
endinterface

// File: rtl/program_loader.sv
// Serial bootloader: 8N1 UART receiver feeding a frame FSM that writes instruction words to memory.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte on each frame.
module program_loader #(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned PC_WIDTH          = 8,
    parameter int unsigned CLOCKS_PER_BIT    = 104,
    parameter logic [7:0]  SYNC_BYTE         = 8'h55
) (
    input  logic             clock,
    input  logic             isReset,
    input  logic             rx,
    program_loader_if.master bus
);
    localparam int unsigned BYTES      = INSTRUCTION_WIDTH / 8;
    localparam int unsigned BYTE_IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W      = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned HALF_BIT   = CLOCKS_PER_BIT / 2;

    // ---------------- UART byte receiver ----------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rxState;
    rx_state_t        rxStateNext;
    logic             rxMeta;
    logic             rxSync;
    logic             rxPrev;
    logic [CNT_W-1:0] bitCount;
    logic [2:0]       bitIndex;
    logic [7:0]       shiftReg;
    logic [7:0]       byteData;
    logic             byteValid;
    logic             frameError;
    logic             bitTick;
    logic             stopTick;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (isReset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    always_comb begin
        rxStateNext = rxState;
        bitTick     = 1'b0;
        stopTick    = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (rxPrev && !rxSync) begin
                    rxStateNext = RX_START;
                end
            end
            RX_START: begin
                // Line high again at mid start bit means it was only a glitch
                if (bitCount == CNT_W'(HALF_BIT - 1)) begin
                    rxStateNext = rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bitCount == CNT_W'(CLOCKS_PER_BIT - 1)) begin
                    bitTick = 1'b1;
                    if (bitIndex == 3'd7) begin
                        rxStateNext = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (bitCount == CNT_W'(CLOCKS_PER_BIT - 1)) begin
                    stopTick    = 1'b1;
                    rxStateNext = RX_IDLE;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            rxState    <= RX_IDLE;
            bitCount   <= '0;
            bitIndex   <= '0;
            shiftReg   <= '0;
            byteData   <= '0;
            byteValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            rxState   <= rxStateNext;
            byteValid <= 1'b0;
            if (rxState == RX_IDLE || rxStateNext != rxState || bitTick) begin
                bitCount <= '0;
            end else begin
                bitCount <= bitCount + CNT_W'(1);
            end
            if (rxState == RX_START) begin
                bitIndex <= '0;
            end
            if (bitTick) begin
                shiftReg <= {rxSync, shiftReg[7:1]};
                bitIndex <= bitIndex + 3'd1;
            end
            if (stopTick) begin
                if (rxSync) begin
                    byteValid <= 1'b1;
                    byteData  <= shiftReg;
                end else begin
                    frameError <= 1'b1;
                end
            end
        end
    end

    // ---------------- Frame loader ----------------
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_DATA,
`ifdef LOADER_CHECKSUM_EN
        LD_CHECK,
`endif
        LD_DONE
    } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t LD_TAIL = LD_CHECK;
`else
    localparam ld_state_t LD_TAIL = LD_DONE;
`endif

    ld_state_t                    ldState;
    ld_state_t                    ldStateNext;
    logic [7:0]                   wordsLeft;
    logic [BYTE_IDX_W-1:0]        byteIndex;
    logic [INSTRUCTION_WIDTH-1:0] wordReg;
    logic [INSTRUCTION_WIDTH-1:0] nextWord;
    logic                         wordLast;
    logic                         lastWord;
    logic                         syncSeen;
    logic                         takeCount;
    logic                         takeData;
    logic                         writeEnable;
    logic [PC_WIDTH-1:0]          writeAddress;
    logic [INSTRUCTION_WIDTH-1:0] writeData;
    logic                         cpuHold;
    logic                         loadDone;
    logic                         checksumError;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                   checksum;
    logic                         checkFail;
`endif

    // Most significant byte arrives first, so new bytes enter at the bottom
    assign nextWord = INSTRUCTION_WIDTH'({wordReg, byteData});
    assign wordLast = (byteIndex == BYTE_IDX_W'(BYTES - 1));
    assign lastWord = (wordsLeft == 8'd1);

    always_comb begin
        ldStateNext = ldState;
        syncSeen    = 1'b0;
        takeCount   = 1'b0;
        takeData    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        checkFail   = 1'b0;
`endif
        case (ldState)
            LD_IDLE: begin
                if (byteValid && byteData == SYNC_BYTE) begin
                    syncSeen    = 1'b1;
                    ldStateNext = LD_COUNT;
                end
            end
            LD_COUNT: begin
                if (byteValid) begin
                    takeCount   = 1'b1;
                    ldStateNext = (byteData == 8'd0) ? LD_TAIL : LD_DATA;
                end
            end
            LD_DATA: begin
                if (byteValid) begin
                    takeData = 1'b1;
                    if (wordLast && lastWord) begin
                        ldStateNext = LD_TAIL;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (byteValid) begin
                    if (byteData == checksum) begin
                        ldStateNext = LD_DONE;
                    end else begin
                        checkFail   = 1'b1;
                        ldStateNext = LD_IDLE;
                    end
                end
            end
`endif
            LD_DONE: ldStateNext = LD_IDLE;
            default: ldStateNext = LD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            ldState      <= LD_IDLE;
            wordsLeft    <= '0;
            byteIndex    <= '0;
            wordReg      <= '0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
            cpuHold      <= 1'b0;
            loadDone     <= 1'b0;
        end else begin
            ldState     <= ldStateNext;
            writeEnable <= 1'b0;
            loadDone    <= 1'b0;
            // Address advances after each strobe; wraps naturally at 2^PC_WIDTH
            if (writeEnable) begin
                writeAddress <= writeAddress + PC_WIDTH'(1);
            end
            if (syncSeen) begin
                cpuHold <= 1'b1;
            end
            if (takeCount) begin
                wordsLeft    <= byteData;
                writeAddress <= '0;
                byteIndex    <= '0;
            end
            if (takeData) begin
                wordReg <= nextWord;
                if (wordLast) begin
                    writeEnable <= 1'b1;
                    writeData   <= nextWord;
                    byteIndex   <= '0;
                    wordsLeft   <= wordsLeft - 8'd1;
                end else begin
                    byteIndex <= byteIndex + BYTE_IDX_W'(1);
                end
            end
            if (ldState == LD_DONE) begin
                loadDone <= 1'b1;
                cpuHold  <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum over data bytes only; a mismatch leaves the CPU held
    always_ff @(posedge clock) begin
        if (isReset) begin
            checksum      <= '0;
            checksumError <= 1'b0;
        end else begin
            if (takeCount) begin
                checksum <= '0;
            end else if (takeData) begin
                checksum <= checksum + byteData;
            end
            if (checkFail) begin
                checksumError <= 1'b1;
            end
        end
    end
`else
    assign checksumError = 1'b0;
`endif

    assign bus.writeEnable   = writeEnable;
    assign bus.writeAddress  = writeAddress;
    assign bus.writeData     = writeData;
    assign bus.cpuHold       = cpuHold;
    assign bus.loadDone      = loadDone;
    assign bus.frameError    = frameError;
    assign bus.checksumError = checksumError;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: drives UART frames, scoreboards memory writes and status flags.
module tb_program_loader;
    localparam int unsigned IW  = 32;
    localparam int unsigned PW  = 8;
    localparam int unsigned CPB = 16;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [IW-1:0] data;
    } wr_t;

    logic clock   = 1'b0;
    logic isReset = 1'b1;
    logic rx      = 1'b1;

    int   checks    = 0;
    int   passes    = 0;
    int   doneCount = 0;
    int   expDone   = 0;
    wr_t  expQ[$];
    wr_t  monExp;
    logic [7:0] csum = 8'd0;
    logic lastWe = 1'b0;

    program_loader_if #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) bus ();

    program_loader #(
        .INSTRUCTION_WIDTH(IW),
        .PC_WIDTH(PW),
        .CLOCKS_PER_BIT(CPB),
        .SYNC_BYTE(8'h55)
    ) dut (
        .clock(clock),
        .isReset(isReset),
        .rx(rx),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/done monitor: every strobe must match the head of the scoreboard
    always @(negedge clock) begin
        if (!isReset) begin
            if (bus.writeEnable) begin
                check("write_expected", 64'(expQ.size() != 0), 64'd1);
                if (expQ.size() != 0) begin
                    monExp = expQ.pop_front();
                    check("write_addr", 64'(bus.writeAddress), 64'(monExp.addr));
                    check("write_data", 64'(bus.writeData), 64'(monExp.data));
                    check("hold_during_write", 64'(bus.cpuHold), 64'd1);
                end
            end
            if (bus.loadDone) begin
                doneCount++;
                check("hold_drops_with_done", 64'(bus.cpuHold), 64'd0);
`ifndef LOADER_CHECKSUM_EN
                check("done_after_write", 64'(lastWe), 64'd1);
`endif
            end
            lastWe = bus.writeEnable;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_we"},   64'(bus.writeEnable),   64'd0);
        check({tag, "_addr"}, 64'(bus.writeAddress),  64'd0);
        check({tag, "_data"}, 64'(bus.writeData),     64'd0);
        check({tag, "_hold"}, 64'(bus.cpuHold),       64'd0);
        check({tag, "_done"}, 64'(bus.loadDone),      64'd0);
        check({tag, "_ferr"}, 64'(bus.frameError),    64'd0);
        check({tag, "_cerr"}, 64'(bus.checksumError), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_word(input logic [PW-1:0] addr, input logic [IW-1:0] w);
        expQ.push_back({addr, w});
        for (int i = IW / 8 - 1; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], 1'b1);
            csum = csum + w[i*8 +: 8];
        end
    endtask

    task automatic pulse_reset();
        isReset = 1'b1;
        @(negedge clock);
        isReset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_state("reset");
        isReset = 1'b0;
        repeat (4) @(negedge clock);

        // Noise before sync must be ignored
        send_byte(8'h00, 1'b1);
        check("noise00_hold", 64'(bus.cpuHold), 64'd0);
        send_byte(8'hFF, 1'b1);
        check("noiseFF_hold", 64'(bus.cpuHold), 64'd0);
        send_byte(8'hAA, 1'b1);
        check("noiseAA_hold", 64'(bus.cpuHold), 64'd0);

        // Short low glitch on idle line
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_hold", 64'(bus.cpuHold), 64'd0);
        check("glitch_ferr", 64'(bus.frameError), 64'd0);

        // Two-word frame
        csum = 8'd0;
        send_byte(8'h55, 1'b1);
        check("sync_hold", 64'(bus.cpuHold), 64'd1);
        send_byte(8'h02, 1'b1);
        send_word(8'd0, 32'h12345678);
        send_word(8'd1, 32'h9ABCDEF0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 1'b1);
`endif
        expDone++;
        repeat (6) @(negedge clock);
        check("frame1_done", 64'(doneCount), 64'(expDone));
        check("frame1_hold", 64'(bus.cpuHold), 64'd0);
        check("frame1_drain", 64'(expQ.size()), 64'd0);

        // Stop-bit error mid-word: corrupted byte is dropped
        csum = 8'd0;
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        expQ.push_back({8'd0, 32'h11223344});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        check("ferr_set", 64'(bus.frameError), 64'd1);
        check("ferr_hold", 64'(bus.cpuHold), 64'd1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAA, 1'b1);
`endif
        expDone++;
        repeat (6) @(negedge clock);
        check("ferr_frame_done", 64'(doneCount), 64'(expDone));
        check("ferr_sticky", 64'(bus.frameError), 64'd1);
        check("ferr_drain", 64'(expQ.size()), 64'd0);
        pulse_reset();
        check("ferr_cleared", 64'(bus.frameError), 64'd0);
        repeat (4) @(negedge clock);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum, then a good frame
        csum = 8'd0;
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(8'd0, 32'hCAFEF00D);
        send_byte(csum + 8'd1, 1'b1);
        repeat (6) @(negedge clock);
        check("cksum_err", 64'(bus.checksumError), 64'd1);
        check("cksum_hold", 64'(bus.cpuHold), 64'd1);
        check("cksum_no_done", 64'(doneCount), 64'(expDone));
        csum = 8'd0;
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(8'd0, 32'h0BADBEEF);
        send_byte(csum, 1'b1);
        expDone++;
        repeat (6) @(negedge clock);
        check("cksum_retry_done", 64'(doneCount), 64'(expDone));
        check("cksum_retry_hold", 64'(bus.cpuHold), 64'd0);
        check("cksum_err_sticky", 64'(bus.checksumError), 64'd1);
        pulse_reset();
        repeat (4) @(negedge clock);
`endif

        // Reset after 3 of 4 bytes of the second word
        csum = 8'd0;
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(8'd0, 32'h01020304);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        check("partial_hold", 64'(bus.cpuHold), 64'd1);
        pulse_reset();
        check_reset_state("midreset");
        repeat (200) @(negedge clock);
        check("midreset_drain", 64'(expQ.size()), 64'd0);
        check("midreset_no_done", 64'(doneCount), 64'(expDone));
        check("midreset_hold", 64'(bus.cpuHold), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
